game_key_ctrl: RTL and testbench

Turns the raw 8-bit USB HID keycode into game controls. The keycode comes from the CPU-written keycode PIO register's `out_port`. The block filters the code for stability, decodes five game keys (W, A, S, D, Space) into a held vector, and generates one-cycle press, release and frame-paced auto-repeat action pulses. It sits directly downstream of the keycode PIO and feeds the player-motion and game-state logic.

---
 rtl/game_key_pkg.sv | 23 ++
 rtl/keycode_debounce.sv | 31 +++
 rtl/game_key_ctrl.sv | 63 ++++++
 tb/tb_game_key_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/game_key_pkg.sv
// game_key_pkg: keycode map, key indices, repeat FSM states and the keycode decoder
package game_key_pkg;
  localparam int NUM_KEYS = 5;
  localparam logic [7:0] KC_W = 8'h1A;
  localparam logic [7:0] KC_A = 8'h04;
  localparam logic [7:0] KC_S = 8'h16;
  localparam logic [7:0] KC_D = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam int KEY_W = 0;
  localparam int KEY_A = 1;
  localparam int KEY_S = 2;
  localparam int KEY_D = 3;
  localparam int KEY_SPACE = 4;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} key_state_t;
  function automatic logic [NUM_KEYS-1:0] kc_decode(input logic [7:0] kc);
    kc_decode = '0;
    kc_decode[KEY_W] = kc == KC_W;
    kc_decode[KEY_A] = kc == KC_A;
    kc_decode[KEY_S] = kc == KC_S;
    kc_decode[KEY_D] = kc == KC_D;
    kc_decode[KEY_SPACE] = kc == KC_SPACE;
  endfunction
endpackage

// File: rtl/keycode_debounce.sv
// keycode_debounce: accepts a keycode once it has been stable for STABLE_CYCLES clk samples
module keycode_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  output logic [7:0] kc_acc,
  output logic       accept
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  logic [7:0] kc_prev;
  logic [SW-1:0] stab_cnt;
  logic same, ripe;
  assign same = keycode == kc_prev;
  assign ripe = same && stab_cnt == SW'(STABLE_CYCLES - 1);
  // accept marks the edge on which kc_acc takes a new value; that value is keycode
  assign accept = ripe && kc_prev != kc_acc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      kc_prev <= '0;
      stab_cnt <= '0;
      kc_acc <= '0;
    end else if (!same) begin
      kc_prev <= keycode;
      stab_cnt <= '0;
    end else begin
      if (stab_cnt < SW'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 1'b1;
      if (ripe) kc_acc <= kc_prev;
    end
endmodule

// File: rtl/game_key_ctrl.sv
// game_key_ctrl: filters the HID keycode, decodes WASD/Space into held keys and
// generates press, release and frame-paced auto-repeat pulses
module game_key_ctrl
  import game_key_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY = 15,
  parameter int REPEAT_RATE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          keycode,
  input  logic                frame_tick,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_act,
  output logic [NUM_KEYS-1:0] key_rel
);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
  logic [7:0] kc_acc;
  logic accept, rep_fire;
  logic [NUM_KEYS-1:0] dec;
  logic [RW-1:0] rep_cnt, rep_cnt_n;
  key_state_t state, state_n;
  keycode_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
    .clk(clk),
    .reset_n(reset_n),
    .keycode(keycode),
    .kc_acc(kc_acc),
    .accept(accept)
  );
  assign dec = kc_decode(keycode);
  // an accept always restarts the repeat timing, so a coincident frame tick is dropped
  always_comb begin
    state_n = state;
    rep_cnt_n = rep_cnt;
    rep_fire = 1'b0;
    if (accept) begin
      state_n = |dec ? DELAY : IDLE;
      rep_cnt_n = '0;
    end else if (frame_tick && state != IDLE) begin
      rep_fire = rep_cnt == (state == DELAY ? RD_LAST : RR_LAST);
      state_n = rep_fire ? REPEAT : state;
      rep_cnt_n = rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rep_cnt <= '0;
      key_held <= '0;
      key_act <= '0;
      key_rel <= '0;
    end else begin
      state <= state_n;
      rep_cnt <= rep_cnt_n;
      key_held <= accept ? dec : key_held;
      key_act <= accept ? dec : rep_fire ? key_held : '0;
      key_rel <= accept ? kc_decode(kc_acc) & ~dec : '0;
    end
endmodule

// File: tb/tb_game_key_ctrl.sv
// tb_game_key_ctrl: directed checks of filtering, decode, press/release and auto-repeat
module tb_game_key_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic frame_tick = 1'b0;
  logic [4:0] key_held, key_act, key_rel;
  int checks = 0;
  int errors = 0;

  game_key_ctrl #(.STABLE_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .keycode(keycode),
    .frame_tick(frame_tick),
    .key_held(key_held),
    .key_act(key_act),
    .key_rel(key_rel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] held, input logic [4:0] act, input logic [4:0] rel);
    chk({tag, ".held"}, key_held, held);
    chk({tag, ".act"}, key_act, act);
    chk({tag, ".rel"}, key_rel, rel);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ftick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    step(2);
    chk_all("reset", 5'b00000, 5'b00000, 5'b00000);
    reset_n = 1'b1;

    // press A: nothing before edge 4, press at edge 4, one-cycle pulse
    keycode = 8'h04;
    step(4);
    chk_all("a_edge3", 5'b00000, 5'b00000, 5'b00000);
    step(1);
    chk_all("a_edge4", 5'b00010, 5'b00010, 5'b00000);
    step(1);
    chk_all("a_edge5", 5'b00010, 5'b00000, 5'b00000);

    // release to 0x00
    keycode = 8'h00;
    step(4);
    chk_all("a_rel3", 5'b00010, 5'b00000, 5'b00000);
    step(1);
    chk_all("a_rel4", 5'b00000, 5'b00000, 5'b00010);
    step(1);
    chk("a_rel5", key_rel, 5'b00000);

    // tick coincides with the accept edge of A and is not counted
    keycode = 8'h04;
    step(4);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk_all("tick_acc", 5'b00010, 5'b00010, 5'b00000);
    ftick();
    chk("tick_1", key_act, 5'b00000);
    step(1);
    ftick();
    chk("tick_2", key_act, 5'b00000);
    step(1);
    ftick();
    chk("tick_3", key_act, 5'b00010);
    step(1);
    chk("tick_3w", key_act, 5'b00000);

    // direct change A -> Space, then repeat at ticks 3, 5, 7
    keycode = 8'h2C;
    step(5);
    chk_all("sp_press", 5'b10000, 5'b10000, 5'b00010);
    for (int i = 1; i <= 8; i++) begin
      ftick();
      chk($sformatf("sp_tick%0d", i), key_act, (i == 3 || i == 5 || i == 7) ? 5'b10000 : 5'b00000);
      step(1);
      chk($sformatf("sp_gap%0d", i), key_act, 5'b00000);
    end

    // D then direct switch to S
    keycode = 8'h07;
    step(5);
    chk_all("d_press", 5'b01000, 5'b01000, 5'b10000);
    keycode = 8'h16;
    step(4);
    chk_all("ds_edge3", 5'b01000, 5'b00000, 5'b00000);
    step(1);
    chk_all("ds_edge4", 5'b00100, 5'b00100, 5'b01000);
    step(1);
    chk_all("ds_edge5", 5'b00100, 5'b00000, 5'b00000);

    // glitch: 3-cycle W burst, transient 0x00, then W stable
    keycode = 8'h00;
    step(6);
    chk("gl_clear", key_held, 5'b00000);
    keycode = 8'h1A;
    step(3);
    keycode = 8'h00;
    step(1);
    chk_all("gl_burst", 5'b00000, 5'b00000, 5'b00000);
    keycode = 8'h1A;
    step(4);
    chk_all("gl_edge3", 5'b00000, 5'b00000, 5'b00000);
    step(1);
    chk_all("gl_edge4", 5'b00001, 5'b00001, 5'b00000);

    // reset in the middle of repeat while W is held
    ftick();
    step(1);
    ftick();
    step(1);
    ftick();
    chk("w_rep", key_act, 5'b00001);
    #2 reset_n = 1'b0;
    #1 chk_all("rst_mid", 5'b00000, 5'b00000, 5'b00000);
    step(2);
    chk_all("rst_hold", 5'b00000, 5'b00000, 5'b00000);
    reset_n = 1'b1;
    step(4);
    chk_all("rst_edge3", 5'b00000, 5'b00000, 5'b00000);
    step(1);
    chk_all("rst_edge4", 5'b00001, 5'b00001, 5'b00000);
    ftick();
    step(1);
    ftick();
    chk("rst_tick2", key_act, 5'b00000);
    step(1);
    ftick();
    chk("rst_tick3", key_act, 5'b00001);

    // unmapped code releases W and stops repeating
    keycode = 8'h55;
    step(5);
    chk_all("unmap", 5'b00000, 5'b00000, 5'b00001);
    for (int i = 1; i <= 4; i++) begin
      ftick();
      chk($sformatf("idle_tick%0d", i), key_act, 5'b00000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
